// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_REFUND = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ITEM_NONE   = 2'd0,
        ITEM_TEA    = 2'd1,
        ITEM_COKE   = 2'd2,
        ITEM_SPRITE = 2'd3
    } item_t;

    localparam logic [7:0] COIN_5      = 8'd5;
    localparam logic [7:0] COIN_10     = 8'd10;
    localparam logic [7:0] COIN_50     = 8'd50;
    localparam logic [7:0] REFUND_UNIT = 8'd5;

endpackage

// File: rtl/btn_edge.sv
// Single-bit rising-edge detector; the history flop clears on reset so a
// level held through reset reports an edge right after release.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_evt
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= i_in;
    end

    assign o_evt = i_in & ~r_q;

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: coin credit, purchase accept/reject,
// timed drop strobes and 5-unit change payout through a handshaked hopper.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_TEA    = 15,
    parameter int PRICE_COKE   = 20,
    parameter int PRICE_SPRITE = 25,
    parameter int CREDIT_MAX   = 50,
    parameter int DROP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cancel,
    input  logic       money_5,
    input  logic       money_10,
    input  logic       money_50,
    input  logic       tea,
    input  logic       coke,
    input  logic       sprite,
    input  logic       coin_ack,
    output logic       vend_tea,
    output logic       vend_coke,
    output logic       vend_sprite,
    output logic       coin_req,
    output logic       coin_reject,
    output logic       avail_tea,
    output logic       avail_coke,
    output logic       avail_sprite,
    output logic       busy,
    output logic [7:0] credit
);

    localparam int               CW       = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_INIT = CW'(DROP_CYCLES - 1);
    localparam logic [7:0]       P_TEA    = 8'(PRICE_TEA);
    localparam logic [7:0]       P_COKE   = 8'(PRICE_COKE);
    localparam logic [7:0]       P_SPRITE = 8'(PRICE_SPRITE);
    localparam logic [8:0]       C_MAX    = 9'(CREDIT_MAX);

    // Event bit order doubles as IDLE priority: bit 0 wins.
    logic [6:0]    w_in;
    logic [6:0]    w_evt;
    logic [8:0]    w_add5;
    logic [8:0]    w_add10;
    item_t         w_buy;
    logic [7:0]    w_price;

    state_t        r_state;
    item_t         r_item;
    logic [7:0]    r_credit;
    logic [CW-1:0] r_drop_cnt;
    logic          r_vend_on;
    logic          r_coin_req;
    logic          r_coin_reject;

    assign w_in = {sprite, coke, tea, money_5, money_10, money_50, cancel};

    btn_edge u_edge [6:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .i_in  (w_in),
        .o_evt (w_evt)
    );

    assign w_add5  = {1'b0, r_credit} + {1'b0, COIN_5};
    assign w_add10 = {1'b0, r_credit} + {1'b0, COIN_10};

    // Only the highest-priority selection is considered; an unaffordable one
    // still masks lower selections in the same cycle.
    always_comb begin
        w_buy   = ITEM_NONE;
        w_price = '0;
        if (w_evt[3:0] == '0) begin
            if (w_evt[4]) begin
                if (r_credit >= P_TEA) begin
                    w_buy   = ITEM_TEA;
                    w_price = P_TEA;
                end
            end else if (w_evt[5]) begin
                if (r_credit >= P_COKE) begin
                    w_buy   = ITEM_COKE;
                    w_price = P_COKE;
                end
            end else if (w_evt[6]) begin
                if (r_credit >= P_SPRITE) begin
                    w_buy   = ITEM_SPRITE;
                    w_price = P_SPRITE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_item        <= ITEM_NONE;
            r_credit      <= '0;
            r_drop_cnt    <= '0;
            r_vend_on     <= 1'b0;
            r_coin_req    <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_reject <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_evt[0]) begin
                        if (r_credit != '0) begin
                            r_state    <= ST_REFUND;
                            r_coin_req <= 1'b1;
                        end
                    end else if (w_evt[1]) begin
                        if (r_credit == '0) r_credit <= COIN_50;
                        else                r_coin_reject <= 1'b1;
                    end else if (w_evt[2]) begin
                        if (w_add10 <= C_MAX) r_credit <= w_add10[7:0];
                        else                  r_coin_reject <= 1'b1;
                    end else if (w_evt[3]) begin
                        if (w_add5 <= C_MAX) r_credit <= w_add5[7:0];
                        else                 r_coin_reject <= 1'b1;
                    end else if (w_buy != ITEM_NONE) begin
                        r_credit   <= r_credit - w_price;
                        r_item     <= w_buy;
                        r_state    <= ST_VEND;
                        r_drop_cnt <= CNT_INIT;
                        r_vend_on  <= 1'b1;
                    end
                end
                ST_VEND: begin
                    if (r_drop_cnt == '0) begin
                        r_vend_on <= 1'b0;
                        r_item    <= ITEM_NONE;
                        if (r_credit != '0) begin
                            r_state    <= ST_REFUND;
                            r_coin_req <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_drop_cnt <= r_drop_cnt - CW'(1);
                    end
                end
                ST_REFUND: begin
                    // Request drops for one cycle after every ack so the hopper
                    // sees a fresh request per coin.
                    if (r_credit == '0) begin
                        r_state    <= ST_IDLE;
                        r_coin_req <= 1'b0;
                    end else if (r_coin_req) begin
                        if (coin_ack) begin
                            r_credit   <= r_credit - REFUND_UNIT;
                            r_coin_req <= 1'b0;
                            if (r_credit == REFUND_UNIT) r_state <= ST_IDLE;
                        end
                    end else begin
                        r_coin_req <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign vend_tea     = r_vend_on && (r_item == ITEM_TEA);
    assign vend_coke    = r_vend_on && (r_item == ITEM_COKE);
    assign vend_sprite  = r_vend_on && (r_item == ITEM_SPRITE);
    assign coin_req     = r_coin_req;
    assign coin_reject  = r_coin_reject;
    assign busy         = (r_state != ST_IDLE);
    assign credit       = r_credit;
    assign avail_tea    = (r_state == ST_IDLE) && (r_credit >= P_TEA);
    assign avail_coke   = (r_state == ST_IDLE) && (r_credit >= P_COKE);
    assign avail_sprite = (r_state == ST_IDLE) && (r_credit >= P_SPRITE);

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: per-cycle vector table plus hand sequences
// for refund handshakes, simultaneous inputs and reset during refund.
module tb_vend_txn_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] btn = '0;   // {sprite, coke, tea, m5, m10, m50, cancel}
    logic       coin_ack = 1'b0;
    logic       vend_tea, vend_coke, vend_sprite, coin_req, coin_reject;
    logic       avail_tea, avail_coke, avail_sprite, busy;
    logic [7:0] credit;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] B_CAN = 7'b0000001;
    localparam logic [6:0] B_M50 = 7'b0000010;
    localparam logic [6:0] B_M10 = 7'b0000100;
    localparam logic [6:0] B_M5  = 7'b0001000;
    localparam logic [6:0] B_TEA = 7'b0010000;
    localparam logic [6:0] B_CK  = 7'b0100000;
    localparam logic [6:0] B_SP  = 7'b1000000;

    vend_txn_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cancel       (btn[0]),
        .money_50     (btn[1]),
        .money_10     (btn[2]),
        .money_5      (btn[3]),
        .tea          (btn[4]),
        .coke         (btn[5]),
        .sprite       (btn[6]),
        .coin_ack     (coin_ack),
        .vend_tea     (vend_tea),
        .vend_coke    (vend_coke),
        .vend_sprite  (vend_sprite),
        .coin_req     (coin_req),
        .coin_reject  (coin_reject),
        .avail_tea    (avail_tea),
        .avail_coke   (avail_coke),
        .avail_sprite (avail_sprite),
        .busy         (busy),
        .credit       (credit)
    );

    always #5 clk = ~clk;

    // flags = {coin_reject, busy, vend_tea, vend_coke, vend_sprite, coin_req, avail_t, avail_c, avail_s}
    typedef struct {
        logic       rst;
        logic [6:0] btn;
        logic [7:0] credit;
        logic [8:0] flags;
    } vec_t;

    function automatic logic [8:0] flags_now();
        return {coin_reject, busy, vend_tea, vend_coke, vend_sprite, coin_req,
                avail_tea, avail_coke, avail_sprite};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        btn = '0;
        coin_ack = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        chk("reset_state", {credit, flags_now()}, {8'd0, 9'd0});
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [6:0] b);
        btn = b;
        tick();
        btn = '0;
        tick();
    endtask

    // Acknowledge every request until busy falls; returns ack count, -1 on timeout.
    task automatic run_refund(output int acks);
        int n;
        acks = 0;
        n = 0;
        while (busy && n < 200) begin
            if (coin_req) begin
                coin_ack = 1'b1;
                acks++;
            end else begin
                coin_ack = 1'b0;
            end
            tick();
            n++;
        end
        coin_ack = 1'b0;
        if (busy) acks = -1;
    endtask

    vec_t vecs[$];

    initial begin
        int acks;
        int c;

        // Overflow: five tens fill to 50, the next five is rejected.
        vecs.push_back('{1'b1, B_M10, 8'd10, 9'b000000000});
        vecs.push_back('{1'b0, '0,    8'd10, 9'b000000000});
        vecs.push_back('{1'b0, B_M10, 8'd20, 9'b000000110});
        vecs.push_back('{1'b0, '0,    8'd20, 9'b000000110});
        vecs.push_back('{1'b0, B_M10, 8'd30, 9'b000000111});
        vecs.push_back('{1'b0, '0,    8'd30, 9'b000000111});
        vecs.push_back('{1'b0, B_M10, 8'd40, 9'b000000111});
        vecs.push_back('{1'b0, '0,    8'd40, 9'b000000111});
        vecs.push_back('{1'b0, B_M10, 8'd50, 9'b000000111});
        vecs.push_back('{1'b0, '0,    8'd50, 9'b000000111});
        vecs.push_back('{1'b0, B_M5,  8'd50, 9'b100000111});
        vecs.push_back('{1'b0, '0,    8'd50, 9'b000000111});
        // Insufficient credit, then an exact-price tea with no change.
        vecs.push_back('{1'b1, B_M10, 8'd10, 9'b000000000});
        vecs.push_back('{1'b0, B_TEA, 8'd10, 9'b000000000});
        vecs.push_back('{1'b0, '0,    8'd10, 9'b000000000});
        vecs.push_back('{1'b0, B_M5,  8'd15, 9'b000000100});
        vecs.push_back('{1'b0, B_TEA, 8'd0,  9'b011000000});
        vecs.push_back('{1'b0, '0,    8'd0,  9'b011000000});
        vecs.push_back('{1'b0, '0,    8'd0,  9'b011000000});
        vecs.push_back('{1'b0, '0,    8'd0,  9'b011000000});
        vecs.push_back('{1'b0, '0,    8'd0,  9'b000000000});
        vecs.push_back('{1'b0, '0,    8'd0,  9'b000000000});

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            btn = vecs[i].btn;
            tick();
            chk($sformatf("vec%0d", i), {credit, flags_now()}, {vecs[i].credit, vecs[i].flags});
        end

        // money_50 only accepted from zero credit; single-coin refund.
        do_reset();
        pulse(B_M5);
        btn = B_M50;
        tick();
        chk("m50_reject", {coin_reject, credit}, {1'b1, 8'd5});
        btn = '0;
        tick();
        pulse(B_CAN);
        run_refund(acks);
        chk("m50_refund_acks", acks, 1);
        chk("m50_refund_end", {busy, credit}, {1'b0, 8'd0});

        // Sprite from 50: 4-cycle drop then five coins of change.
        do_reset();
        pulse(B_M50);
        chk("m50_accept", credit, 8'd50);
        btn = B_SP;
        tick();
        btn = '0;
        chk("sprite_buy", {credit, vend_sprite, vend_tea, vend_coke}, {8'd25, 3'b100});
        c = 0;
        while (vend_sprite && c < 20) begin
            c++;
            tick();
        end
        chk("sprite_drop_len", c, 4);
        chk("sprite_to_refund", {busy, coin_req, credit}, {2'b11, 8'd25});
        run_refund(acks);
        chk("sprite_refund_acks", acks, 5);
        chk("sprite_refund_end", {busy, credit, coin_req}, {1'b0, 8'd0, 1'b0});

        // Simultaneous cancel/m10/coke: only cancel acts; held levels stay quiet.
        do_reset();
        pulse(B_M10);
        pulse(B_M10);
        btn = B_CAN | B_M10 | B_CK;
        tick();
        chk("simul_cancel", {busy, coin_req, credit, vend_coke}, {2'b11, 8'd20, 1'b0});
        run_refund(acks);
        chk("simul_acks", acks, 4);
        repeat (3) tick();
        chk("held_no_retrigger", {credit, flags_now()}, {8'd0, 9'd0});
        btn = '0;
        tick();

        // Reset in the middle of a refund drops the remaining credit.
        do_reset();
        pulse(B_M10);
        pulse(B_M10);
        pulse(B_M10);
        pulse(B_CAN);
        acks = 0;
        c = 0;
        while (acks < 2 && c < 50) begin
            if (coin_req) begin
                coin_ack = 1'b1;
                acks++;
            end else begin
                coin_ack = 1'b0;
            end
            tick();
            c++;
        end
        coin_ack = 1'b0;
        chk("mid_refund_credit", {busy, credit}, {1'b1, 8'd20});
        rst_n = 1'b0;
        tick();
        chk("mid_refund_reset", {credit, coin_req, busy}, {8'd0, 2'b00});
        rst_n = 1'b1;
        coin_ack = 1'b1;
        repeat (5) tick();
        chk("ack_after_reset", {credit, flags_now()}, {8'd0, 9'd0});
        coin_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
